// File: rtl/spi_slave_seq.sv
// SPI mode-0 register-frame sequencer, run entirely in the sclk domain.
// Parses a rw+address command, then streams data words with address auto-increment.
module spi_slave_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

    localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W = (SH_W > 1) ? $clog2(SH_W) : 1;

    typedef enum logic {
        CMD,
        DATA
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [SH_W-2:0]   sh;
    logic [SH_W-1:0]   sh_n;
    logic              rw, rw_n;
    logic              cmd_done;
    logic              word_done;
    logic [DATA_W-1:0] tx;

    always_comb begin
        sh_n      = {sh, mosi};
        cmd_done  = (state == CMD) && (bit_cnt == CNT_W'(ADDR_W));
        word_done = (state == DATA) && (bit_cnt == CNT_W'(DATA_W - 1));
        state_n   = state;
        rw_n      = rw;
        bit_cnt_n = bit_cnt + 1'b1;
        if (cmd_done) begin
            state_n   = DATA;
            rw_n      = sh_n[ADDR_W];
            bit_cnt_n = '0;
        end
        if (word_done) begin
            bit_cnt_n = '0;
        end
    end

    // ss high aborts the frame; strobes drop at once
    always_ff @(posedge sclk or posedge rst or posedge ss) begin
        if (rst || ss) begin
            state   <= CMD;
            bit_cnt <= '0;
            sh      <= '0;
            rw      <= 1'b0;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            sh      <= sh_n[SH_W-2:0];
            rw      <= rw_n;
            reg_we  <= word_done && rw;
            reg_re  <= (cmd_done && !rw_n) || (word_done && !rw);
        end
    end

    // address and write data survive ss so the bank sees stable values
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else if (!ss) begin
            if (cmd_done) begin
                reg_addr <= sh_n[ADDR_W-1:0];
            end else if (reg_we || (word_done && !rw)) begin
                reg_addr <= reg_addr + 1'b1;
            end
            if (word_done && rw) begin
                reg_wdata <= sh_n[DATA_W-1:0];
            end
        end
    end

    always_ff @(negedge sclk or posedge rst or posedge ss) begin
        if (rst || ss) begin
            tx <= '0;
        end else if (reg_re) begin
            tx <= reg_rdata;
        end else if (state == DATA) begin
            tx <= {tx[DATA_W-2:0], 1'b0};
        end
    end

    assign miso = (state == DATA) && tx[DATA_W-1];
    assign busy = (state != CMD) || (bit_cnt != '0);

endmodule

// File: tb/tb_spi_slave_seq.sv
// Directed bench for spi_slave_seq: master-driven frames against a small
// register-bank model with write and read-strobe logs.
module tb_spi_slave_seq;

    logic        sclk;
    logic        rst;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        busy;

    logic [31:0] mem [128];
    logic [6:0]  we_a [$];
    logic [31:0] we_d [$];
    logic [6:0]  re_a [$];

    int n_chk;
    int n_pass;
    logic        cmd_miso;
    logic [31:0] rd;

    spi_slave_seq dut (
        .sclk      (sclk),
        .rst       (rst),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    assign reg_rdata = mem[reg_addr];

    always @(negedge sclk) begin
        if (reg_we) begin
            mem[reg_addr] = reg_wdata;
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
        end
        if (reg_re) begin
            re_a.push_back(reg_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xbit(input logic b, output logic m);
        mosi = b;
        #5;
        m = miso;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic m;
        cmd_miso = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            xbit(c[i], m);
            cmd_miso = cmd_miso | m;
        end
    endtask

    task automatic send_word(input logic [31:0] w, output logic [31:0] r);
        logic m;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            xbit(w[i], m);
            r[i] = m;
        end
    endtask

    task automatic frame_start();
        we_a.delete();
        we_d.delete();
        re_a.delete();
        ss = 1'b0;
        #5;
    endtask

    task automatic frame_end();
        #5;
        ss = 1'b1;
        #10;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        sclk   = 1'b0;
        mosi   = 1'b0;
        ss     = 1'b1;
        rst    = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #1;
        rst = 1'b1;
        #10;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_addr", 32'(reg_addr), 32'h0);
        check("rst_wdata", reg_wdata, 32'h0);
        check("rst_we", 32'(reg_we), 32'h0);
        check("rst_re", 32'(reg_re), 32'h0);
        rst = 1'b0;
        #10;

        // single write
        frame_start();
        send_cmd(8'h85);
        check("wr_busy_mid", 32'(busy), 32'h1);
        send_word(32'hDEADBEEF, rd);
        frame_end();
        check("wr_cnt", we_a.size(), 1);
        if (we_a.size() >= 1) begin
            check("wr_addr", 32'(we_a[0]), 32'h05);
            check("wr_data", we_d[0], 32'hDEADBEEF);
        end
        check("wr_busy_end", 32'(busy), 32'h0);
        check("wr_mem", mem[5], 32'hDEADBEEF);

        // single read
        mem[10] = 32'h12345678;
        frame_start();
        send_cmd(8'h0A);
        check("rd_cmd_miso", 32'(cmd_miso), 32'h0);
        send_word(32'h0, rd);
        frame_end();
        check("rd_data", rd, 32'h12345678);
        check("rd_re_first", re_a.size() >= 1 ? 32'(re_a[0]) : 32'hFFFF, 32'h0A);
        check("rd_no_we", we_a.size(), 0);

        // burst write wrapping past 0x7F
        frame_start();
        send_cmd(8'hFF);
        send_word(32'h11111111, rd);
        send_word(32'h22222222, rd);
        send_word(32'h33333333, rd);
        frame_end();
        check("bw_cnt", we_a.size(), 3);
        if (we_a.size() == 3) begin
            check("bw_a0", 32'(we_a[0]), 32'h7F);
            check("bw_d0", we_d[0], 32'h11111111);
            check("bw_a1", 32'(we_a[1]), 32'h00);
            check("bw_d1", we_d[1], 32'h22222222);
            check("bw_a2", 32'(we_a[2]), 32'h01);
            check("bw_d2", we_d[2], 32'h33333333);
        end

        // burst read, back-to-back words
        mem[3] = 32'hA5A5F00F;
        mem[4] = 32'h0BADCAFE;
        mem[5] = 32'hC001D00D;
        frame_start();
        send_cmd(8'h03);
        send_word(32'h0, rd);
        check("br_w0", rd, 32'hA5A5F00F);
        send_word(32'h0, rd);
        check("br_w1", rd, 32'h0BADCAFE);
        send_word(32'h0, rd);
        check("br_w2", rd, 32'hC001D00D);
        frame_end();
        check("br_re_cnt_ge3", 32'(re_a.size() >= 3), 32'h1);
        if (re_a.size() >= 3) begin
            check("br_re0", 32'(re_a[0]), 32'h03);
            check("br_re1", 32'(re_a[1]), 32'h04);
            check("br_re2", 32'(re_a[2]), 32'h05);
        end

        // abort mid-word
        frame_start();
        send_cmd(8'h90);
        for (int i = 0; i < 20; i++) xbit(1'b1, cmd_miso);
        frame_end();
        check("ab_no_we", we_a.size(), 0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_mem", mem[16], 32'h0);
        frame_start();
        send_cmd(8'h81);
        send_word(32'h00000001, rd);
        frame_end();
        check("ab_next_cnt", we_a.size(), 1);
        if (we_a.size() >= 1) begin
            check("ab_next_addr", 32'(we_a[0]), 32'h01);
            check("ab_next_data", we_d[0], 32'h00000001);
        end

        // reset mid-command
        frame_start();
        for (int i = 0; i < 5; i++) xbit(1'b1, cmd_miso);
        check("mr_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_addr", 32'(reg_addr), 32'h0);
        check("mr_wdata", reg_wdata, 32'h0);
        check("mr_we", 32'(reg_we), 32'h0);
        #5;
        rst = 1'b0;
        frame_end();
        frame_start();
        send_cmd(8'h82);
        send_word(32'hCAFEF00D, rd);
        frame_end();
        check("mr_wr_cnt", we_a.size(), 1);
        if (we_a.size() >= 1) begin
            check("mr_wr_addr", 32'(we_a[0]), 32'h02);
            check("mr_wr_data", we_d[0], 32'hCAFEF00D);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_seq.md
Name: spi_slave_seq

Overview:
Frame sequencer for the SPI slave path. It parses mode-0 SPI frames (command byte followed by one or more data words) directly in the sclk domain, and drives a simple register-bank port with address, write data, write strobe and read strobe. It shifts register read data out on miso and auto-increments the address for burst transfers. It replaces ad-hoc software polling of raw shift registers with a self-sequenced register protocol.

Parameters:
DATA_W, 32, data word width in bits; frame data phase length per word.
ADDR_W, 7, register address width; command field is 1+ADDR_W bits.

Ports:
sclk  input  1  SPI serial clock, mode 0 (sample on posedge, drive on negedge).
rst  input  1  reset.
ss  input  1  slave select, active low; high = frame terminated.
mosi  input  1  master out slave in, MSB first.
miso  output  1  slave out, MSB first.
reg_addr  output  ADDR_W  register address.
reg_wdata  output  DATA_W  register write data.
reg_we  output  1  write strobe; bank captures reg_wdata at reg_addr on negedge sclk while high.
reg_re  output  1  read strobe; one sclk cycle, marks reg_addr valid for a read.
reg_rdata  input  DATA_W  combinational read data for reg_addr; must settle within half an sclk period.
busy  output  1  high while a frame is in progress (state != CMD or bit count != 0).

Behaviour:
- Reset: rst is asynchronous, active-high; the block is clocked by sclk. ss high is also an asynchronous clear of the frame logic.
- Reset values: state=CMD, bit counter=0, reg_we=0, reg_re=0, tx shift=0, miso=0, busy=0. reg_addr=0 and reg_wdata=0 on rst only; ss does not clear them.
- States:
  - CMD: shift 1+ADDR_W bits. First bit is rw (1=write, 0=read); the remaining ADDR_W bits are the address, MSB first.
  - DATA: shift DATA_W-bit words repeatedly until ss rises.
- Bit counter: counts posedges within the current field; wraps to 0 at field end.
- CMD end (posedge sampling the last address bit):
  - reg_addr <= parsed address; rw latched; go to DATA.
  - If read: reg_re=1 for this sclk cycle.
- Read data path:
  - On the negedge following a reg_re posedge, the tx shift register loads reg_rdata.
  - On every other negedge in DATA, it shifts left by 1.
  - miso = tx MSB in DATA; miso=0 in CMD.
- Read word end (posedge of the last bit of a word): reg_addr <= reg_addr+1 (mod 2^ADDR_W); reg_re=1 for one cycle, so the next word is loaded on the following negedge with no gap.
- Write word end (posedge sampling the last data bit):
  - reg_wdata <= full assembled word (including that bit); reg_we=1.
  - The bank commits on the following negedge.
  - On the next posedge: reg_we=0, reg_addr <= reg_addr+1 (mod 2^ADDR_W).
- reg_we and reg_re deassert on the next posedge, or immediately on ss rise or rst.
  - Mode 0 guarantees a negedge after the last posedge before ss rises, so a completed word is always committed.
- Write data during DATA: mosi is ignored for reads.
- ss rises mid-field (CMD or partial word): frame aborted; no reg_we for the partial word; state returns to CMD.
- ss low with no sclk: no state change.
- rst mid-frame: all state returns to reset values immediately; the next frame starts at CMD.

Test Plan:
- Single write (DATA_W=32, ADDR_W=7): ss low, cmd 0x85, data 0xDEADBEEF, ss high -> exactly one reg_we pulse with reg_addr=0x05, reg_wdata=0xDEADBEEF; busy=0 after ss.
- Single read: bank returns 0x12345678 at addr 0x0A; cmd 0x0A, 32 clocks -> reg_re pulse with reg_addr=0x0A; miso shifts 0x12345678 MSB first; miso=0 during cmd.
- Burst write with wrap: cmd 0xFF, words 0x11111111, 0x22222222, 0x33333333 -> reg_we at addrs 0x7F, 0x00, 0x01 with matching data.
- Burst read: cmd 0x03, 96 data clocks; bank mem[3..5]=A,B,C -> miso returns A,B,C back-to-back; 3 reg_re pulses at 0x03, 0x04, 0x05.
- Abort: cmd 0x90, 20 data bits, ss high -> no reg_we; the next frame (cmd 0x81, 0x00000001) writes only addr 0x01.
- Reset mid-frame: assert rst after 5 cmd bits -> outputs at reset values at once; a following full write frame to 0x02 completes correctly.
